cyclic_syndrome_check: RTL and testbench



---
 rtl/cyclic_syndrome_check.sv | 124 ++++++++++++
 tb/tb_cyclic_syndrome_check.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_syndrome_check.sv
// cyclic_syndrome_check
// Receive-side syndrome checker for systematic cyclic codes over GF(2).
// A codeword arrives as N_BEATS beats of W bits each, with the MSB first.
// A W-step unrolled LFSR divides the codeword by GEN. The P-bit remainder is
// presented on a valid/ready output together with a nonzero flag.
// Optional feature macro: CYCLIC_SYNDROME_CHECK_STATS_EN adds a saturating
// err_count output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid (and its data stable) until that edge.
// ready may depend on state but never on the same-cycle valid.
//
// The FSM state is held in the internal register `state`, where external
// checkers can bind to it.

module cyclic_syndrome_check #(
  parameter int           P       = 8,
  parameter logic [P:0]   GEN     = 9'h107,
  parameter int           W       = 4,
  parameter int           N_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         syn_valid,
  input  logic         syn_ready,
  output logic [P-1:0] syn,
  output logic         syn_err
`ifdef CYCLIC_SYNDROME_CHECK_STATS_EN
  ,
  output logic [15:0]  err_count
`endif
);

  localparam int CW = $clog2(N_BEATS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [P-1:0]  r;
  logic [P-1:0]  r_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_beat;

  // Perform one serial division step: shift in bit b, then reduce by GEN when x^P falls out.
  function automatic logic [P-1:0] lfsr_step(input logic [P-1:0] cur, input logic b);
    logic [P-1:0] s;
    s    = cur << 1;
    s[0] = b;
    if (cur[P-1]) s = s ^ GEN[P-1:0];
    return s;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign accept    = in_ready && in_valid;
  assign last_beat = (cnt == CW'(N_BEATS - 1));

  // Apply all W steps of the current beat in one cycle, MSB first.
  always_comb begin
    r_next = r;
    for (int i = W - 1; i >= 0; i--) begin
      r_next = lfsr_step(r_next, in_data[i]);
    end
  end

  // Control FSM, remainder register, beat counter and the registered syndrome outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      cnt       <= '0;
      syn       <= '0;
      syn_err   <= 1'b0;
      syn_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ACCUM;
        ACCUM: begin
          if (accept) begin
            r <= r_next;
            if (last_beat) begin
              state     <= DONE;
              cnt       <= '0;
              syn       <= r_next;
              syn_err   <= |r_next;
              syn_valid <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (syn_ready) begin
            state     <= ACCUM;
            r         <= '0;
            syn_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CYCLIC_SYNDROME_CHECK_STATS_EN
  logic [15:0] err_count_q;

  // Count syndrome handshakes that report an error, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if (syn_valid && syn_ready && syn_err && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_cyclic_syndrome_check.sv
// Bench for cyclic_syndrome_check: directed codewords from the test plan plus
// randomized codewords, gaps and backpressure. Every result is compared with a
// polynomial long-division reference model.
module tb_cyclic_syndrome_check;

  localparam int         P   = 8;
  localparam logic [P:0] GEN = 9'h107;
  localparam int         W   = 4;
  localparam int         NB  = 4;
  localparam int         TOT = W * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         syn_valid;
  logic         syn_ready = 1'b0;
  logic [P-1:0] syn;
  logic         syn_err;
`ifdef CYCLIC_SYNDROME_CHECK_STATS_EN
  logic [15:0]  err_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  int n_syn    = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic [P-1:0] exp_q[$];
  logic [15:0]  exp_err_cnt = '0;

  cyclic_syndrome_check #(.P(P), .GEN(GEN), .W(W), .N_BEATS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn       (syn),
    .syn_err   (syn_err)
`ifdef CYCLIC_SYNDROME_CHECK_STATS_EN
    ,
    .err_count (err_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: c(x) mod GEN by long division on the whole codeword.
  function automatic logic [P-1:0] ref_mod(input logic [TOT-1:0] c);
    logic [TOT-1:0] v;
    logic [TOT-1:0] g;
    v = c;
    g = TOT'(GEN);
    for (int i = TOT - 1; i >= P; i--) begin
      if (v[i]) v = v ^ (g << (i - P));
    end
    return v[P-1:0];
  endfunction

  // Produce a codeword that is a multiple of GEN: m(x) * GEN(x).
  function automatic logic [TOT-1:0] make_valid(input logic [TOT-1:0] m);
    logic [TOT-1:0] cw;
    logic [TOT-1:0] g;
    cw = '0;
    g  = TOT'(GEN);
    for (int i = 0; i < TOT - P; i++) begin
      if (m[i]) cw = cw ^ (g << i);
    end
    return cw;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_err_cnt = '0;
  endtask

  // Driver: present nb beats of cw (MSB nibble first), optionally with idle gaps.
  task automatic send_beats(input logic [TOT-1:0] cw, input int nb, input bit gaps, output bit ok);
    int t;
    int g;
    ok = 1'b1;
    for (int k = 0; k < nb; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = W'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = cw[TOT-1-k*W -: W];
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        check("accept_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic send_codeword(input logic [TOT-1:0] cw, input logic [P-1:0] exp, input bit gaps);
    bit ok;
    send_beats(cw, NB, gaps, ok);
    if (ok) begin
      exp_q.push_back(exp);
      n_sent++;
      #1 check("syn_valid_latency", 32'(syn_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard / monitor: drives syn_ready and checks outputs at every falling edge.
  initial begin
    bit           prev_v;
    bit           prev_hs;
    bit           hs;
    logic [P-1:0] prev_syn;
    logic [P-1:0] e;
    prev_v = 1'b0;
    prev_hs = 1'b0;
    prev_syn = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_hs = 1'b0;
        syn_ready = 1'b0;
      end else begin
        if (prev_hs) begin
          check("bubble_syn_valid", 32'(syn_valid), 32'd0);
          check("bubble_in_ready", 32'(in_ready), 32'd1);
        end else if (prev_v) begin
          check("hold_syn_valid", 32'(syn_valid), 32'd1);
          check("hold_syn", 32'(syn), 32'(prev_syn));
        end
        if (syn_valid) check("in_ready_in_done", 32'(in_ready), 32'd0);
        case (ready_mode)
          0:       syn_ready = 1'b1;
          1:       syn_ready = 1'($urandom_range(0, 1));
          default: syn_ready = 1'b0;
        endcase
        hs = syn_valid && syn_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check("unexpected_syndrome", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("syn", 32'(syn), 32'(e));
            check("syn_err", 32'(syn_err), 32'(e != '0));
            n_syn++;
            if (e != '0 && exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
          end
        end
        prev_v = syn_valid;
        prev_hs = hs;
        prev_syn = syn;
      end
    end
  end

  // Main sequence
  initial begin
    bit             ok;
    logic [TOT-1:0] cw;
    int             kind;

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_syn_valid", 32'(syn_valid), 32'd0);
    check("rst_syn", 32'(syn), 32'd0);
    check("rst_syn_err", 32'(syn_err), 32'd0);
`ifdef CYCLIC_SYNDROME_CHECK_STATS_EN
    check("rst_err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 check("accum_in_ready", 32'(in_ready), 32'd1);

    // Directed codewords
    ready_mode = 0;
    send_codeword(16'h0000, 8'h00, 1'b0);
    send_codeword(16'h0107, 8'h00, 1'b0);
    send_codeword(16'h0106, 8'h01, 1'b0);
    send_codeword(16'h0007, 8'h07, 1'b0);

    // Backpressure and gaps
    drain();
    ready_mode = 2;
    send_codeword(16'h0107, 8'h00, 1'b1);
    repeat (10) @(negedge clk);
    ready_mode = 0;
    send_codeword(16'h0106, 8'h01, 1'b1);
    drain();

    // Reset mid-codeword: only the following full codeword yields a syndrome
    send_beats(16'h0106, 2, 1'b0, ok);
    #1 rst_n = 1'b0;
    in_data = 4'hF;
    #1 check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_syn_valid", 32'(syn_valid), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    send_codeword(16'h0107, 8'h00, 1'b0);
    drain();
    check("syndrome_count", 32'(n_syn), 32'(n_sent));

    // Randomized codewords with random gaps and backpressure
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0)      cw = make_valid(TOT'($urandom));
      else if (kind == 1) cw = make_valid(TOT'($urandom)) ^ (TOT'(1) << $urandom_range(0, TOT - 1));
      else                cw = TOT'($urandom);
      send_codeword(cw, ref_mod(cw), 1'($urandom_range(0, 1)));
    end
    ready_mode = 0;
    drain();
    check("syndrome_count_final", 32'(n_syn), 32'(n_sent));

`ifdef CYCLIC_SYNDROME_CHECK_STATS_EN
    apply_reset();
    send_codeword(16'h0106, 8'h01, 1'b0);
    send_codeword(16'h0107, 8'h00, 1'b0);
    send_codeword(16'h0007, 8'h07, 1'b0);
    drain();
    @(negedge clk);
    check("err_count_three", 32'(err_count), 32'd2);
    check("err_count_model", 32'(err_count), 32'(exp_err_cnt));
    @(negedge clk);
    force dut.err_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_count_q;
    exp_err_cnt = 16'hFFFF;
    send_codeword(16'h0106, 8'h01, 1'b0);
    drain();
    @(negedge clk);
    check("err_count_saturate", 32'(err_count), 32'(exp_err_cnt));
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
